// File: rtl/xor_decryptor.sv
// Streams a message out of cipher/key RAMs, XORs them and writes the plaintext RAM, one byte per clock.
// Optional build macro DECRY_CHECKSUM_EN adds a running XOR checksum of every written plaintext byte.
module xor_decryptor #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_decryption,
  input  logic [ADDR_W:0]   msg_len,
  output logic [ADDR_W-1:0] cipher_addr,
  input  logic [DATA_W-1:0] cipher_data,
  output logic [ADDR_W-1:0] key_addr,
  input  logic [DATA_W-1:0] key_data,
  output logic              plain_we,
  output logic [ADDR_W-1:0] plain_addr,
  output logic [DATA_W-1:0] plain_data,
  output logic              decry_completed,
  output logic              busy,
`ifdef DECRY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic                en_q, armed_q;
  logic [ADDR_W:0]     len_q, rd_cnt_q;
  logic [ADDR_W-1:0]   addr_q, dv_addr_q, waddr_q;
  logic                av_q, dv_q, we_q, done_q, busy_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                start_edge;
  logic [ADDR_W:0]     len_d, last_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                wr_fire, last_wr;

  // Protocol: en_decryption is a level held for the whole job; only its rising
  // edge starts work, and dropping it aborts. plain_we is a one-cycle write strobe
  // with no back-pressure. armed_q blocks a start until enable has been seen low
  // after reset, so an enable held high across reset cannot restart the block.
  assign start_edge = en_decryption & ~en_q & armed_q;
  assign len_d      = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
  assign last_d     = len_q - ONE;
  assign wdata_d    = cipher_data ^ key_data;
  assign wr_fire    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && en_decryption && dv_q;
  assign last_wr    = wr_fire && ({1'b0, dv_addr_q} == last_d);

  // av_q: a fresh read address is on the RAM bus; dv_q: its data is on the read bus now.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      armed_q   <= 1'b0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      addr_q    <= '0;
      av_q      <= 1'b0;
      dv_q      <= 1'b0;
      dv_addr_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      en_q      <= en_decryption;
      armed_q   <= armed_q | ~en_decryption;
      av_q      <= 1'b0;
      dv_q      <= av_q;
      dv_addr_q <= addr_q;
      we_q      <= wr_fire;
      done_q    <= 1'b0;
      if (wr_fire) begin
        waddr_q <= dv_addr_q;
        wdata_q <= wdata_d;
      end
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            len_q <= len_d;
            if (len_d == '0) begin
              state_q <= S_DONE;
            end else begin
              addr_q   <= '0;
              rd_cnt_q <= ONE;
              av_q     <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= (len_d == ONE) ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!en_decryption) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
          end else begin
            addr_q   <= rd_cnt_q[ADDR_W-1:0];
            rd_cnt_q <= rd_cnt_q + ONE;
            av_q     <= 1'b1;
            if (rd_cnt_q == last_d) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!en_decryption) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
          end else if (last_wr) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DECRY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE) && start_edge) begin
      csum_q <= '0;
    end else if (wr_fire) begin
      csum_q <= csum_q ^ wdata_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign cipher_addr     = addr_q;
  assign key_addr        = addr_q;
  assign plain_we        = we_q;
  assign plain_addr      = waddr_q;
  assign plain_data      = wdata_q;
  assign decry_completed = done_q;
  assign busy            = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_xor_decryptor.sv
// Randomized bench for xor_decryptor: RAM models, expected-write scoreboard built
// directly from the message contents, latency and abort/reset checks.
module tb_xor_decryptor;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic [ADDR_W:0]   msg_len = '0;
  logic [ADDR_W-1:0] cipher_addr, key_addr, plain_addr;
  logic [DATA_W-1:0] cipher_data = '0;
  logic [DATA_W-1:0] key_data = '0;
  logic [DATA_W-1:0] plain_data;
  logic              plain_we, decry_completed, busy;
  logic [1:0]        dbg_state;
`ifdef DECRY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  xor_decryptor #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .en_decryption   (en),
    .msg_len         (msg_len),
    .cipher_addr     (cipher_addr),
    .cipher_data     (cipher_data),
    .key_addr        (key_addr),
    .key_data        (key_data),
    .plain_we        (plain_we),
    .plain_addr      (plain_addr),
    .plain_data      (plain_data),
    .decry_completed (decry_completed),
    .busy            (busy),
`ifdef DECRY_CHECKSUM_EN
    .checksum        (checksum),
`endif
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous-read RAM models
  logic [DATA_W-1:0] cipher_mem [DEPTH];
  logic [DATA_W-1:0] key_mem    [DEPTH];
  logic [DATA_W-1:0] plain_mem  [DEPTH];

  always @(posedge clk) begin
    cipher_data <= cipher_mem[cipher_addr];
    key_data    <= key_mem[key_addr];
  end

  // scoreboard
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] last_csum = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      cipher_mem[i] = DATA_W'($urandom);
      key_mem[i]    = DATA_W'($urandom);
      plain_mem[i]  = '0;
    end
  endtask

  // One job: en low for a cycle, then a rising edge. drop_at >= 2 drops enable
  // right after observing that many cycles past the start edge.
  task automatic run_job(input int len, input int drop_at);
    int l, writes, first_wr, done_k, pulses;
    logic [ADDR_W+DATA_W-1:0] e;
    logic [DATA_W-1:0] csum_exp;
    l = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    csum_exp = '0;
    for (int c = 0; c < l; c++) begin
      exp_q.push_back({ADDR_W'(c), cipher_mem[c] ^ key_mem[c]});
      csum_exp ^= cipher_mem[c] ^ key_mem[c];
    end
    @(negedge clk) en = 1'b0;
    @(negedge clk) begin
      en = 1'b1;
      msg_len = (ADDR_W + 1)'(len);
    end
    writes = 0; first_wr = -1; done_k = -1; pulses = 0;
    for (int k = 0; k < l + 8; k++) begin
      @(negedge clk);
      if (plain_we) begin
        writes++;
        if (first_wr < 0) first_wr = k;
        plain_mem[plain_addr] = plain_data;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(plain_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
          check_eq("wr_data", 32'(plain_data), 32'(e[DATA_W-1:0]));
        end
      end
      if (decry_completed) begin
        pulses++;
        done_k = k;
`ifdef DECRY_CHECKSUM_EN
        last_csum = checksum;
        check_eq("checksum", 32'(checksum), 32'(csum_exp));
`endif
      end
      check_eq("key_addr_eq", 32'(key_addr), 32'(cipher_addr));
      if (k < l && (drop_at < 0 || k <= drop_at))
        check_eq("rd_addr", 32'(cipher_addr), 32'(k));
      if (drop_at < 0 && l > 0 && k == l)     check_eq("busy_run", 32'(busy), 32'd1);
      if (drop_at < 0 && k == l + 1)          check_eq("busy_end", 32'(busy), 32'd0);
      if (drop_at >= 0 && k == drop_at + 1)   check_eq("busy_abort", 32'(busy), 32'd0);
      if (drop_at >= 0 && k == drop_at) en = 1'b0;
    end
    if (drop_at < 0) begin
      check_eq("wr_count", 32'(writes), 32'(l));
      check_eq("first_wr", 32'(first_wr), (l > 0) ? 32'd2 : 32'hFFFF_FFFF);
      check_eq("done_lat", 32'(done_k), (l > 0) ? 32'(l + 2) : 32'd1);
      check_eq("done_pulses", 32'(pulses), 32'd1);
    end else begin
      check_eq("abort_writes", 32'(writes), 32'(drop_at - 1));
      check_eq("abort_pulses", 32'(pulses), 32'd0);
    end
    en = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int len, drop, we_seen, busy_seen, done_seen;
    for (int i = 0; i < DEPTH; i++) begin
      cipher_mem[i] = '0;
      key_mem[i]    = '0;
      plain_mem[i]  = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_we", 32'(plain_we), 32'd0);
    check_eq("rst_done", 32'(decry_completed), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_caddr", 32'(cipher_addr), 32'd0);
    check_eq("rst_paddr", 32'(plain_addr), 32'd0);
    check_eq("rst_pdata", 32'(plain_data), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // two-byte reference message
    cipher_mem[0] = 8'h48 ^ 8'h5A;  key_mem[0] = 8'h5A;
    cipher_mem[1] = 8'h69 ^ 8'hA5;  key_mem[1] = 8'hA5;
    run_job(2, -1);
    check_eq("ref_p0", 32'(plain_mem[0]), 32'h48);
    check_eq("ref_p1", 32'(plain_mem[1]), 32'h69);

    // zero length, single byte, clamped length
    run_job(0, -1);
    fill_random();
    run_job(1, -1);
    fill_random();
    run_job(40, -1);
    for (int i = 0; i < DEPTH; i++)
      check_eq("full_mem", 32'(plain_mem[i]), 32'(cipher_mem[i] ^ key_mem[i]));

    // plaintext 01 02 04 -> checksum 07
    for (int i = 0; i < DEPTH; i++) key_mem[i] = '0;
    cipher_mem[0] = 8'h01; cipher_mem[1] = 8'h02; cipher_mem[2] = 8'h04;
    run_job(3, -1);
`ifdef DECRY_CHECKSUM_EN
    check_eq("csum_147", 32'(last_csum), 32'h07);
`endif

    // abort, then fresh restart from address 0
    fill_random();
    run_job(10, 5);
    run_job(10, -1);

    // async reset in the middle of a run, enable held high afterwards
    fill_random();
    @(negedge clk) en = 1'b0;
    @(negedge clk) begin
      en = 1'b1;
      msg_len = 7'd20;
    end
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_we", 32'(plain_we), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_caddr", 32'(cipher_addr), 32'd0);
    check_eq("arst_paddr", 32'(plain_addr), 32'd0);
    check_eq("arst_pdata", 32'(plain_data), 32'd0);
    @(negedge clk) reset = 1'b1;
    we_seen = 0; busy_seen = 0; done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (plain_we) we_seen++;
      if (busy) busy_seen++;
      if (decry_completed) done_seen++;
    end
    check_eq("hold_no_we", 32'(we_seen), 32'd0);
    check_eq("hold_no_busy", 32'(busy_seen), 32'd0);
    check_eq("hold_no_done", 32'(done_seen), 32'd0);
    run_job(6, -1);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      fill_random();
      len = int'($urandom_range(0, 40));
      drop = -1;
      if (len >= 4 && $urandom_range(0, 2) == 0)
        drop = int'($urandom_range(2, (len > DEPTH) ? DEPTH : len));
      run_job(len, drop);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
